// File: rtl/onchip_ram_dualport_arb_if.sv
// Avalon-MM slave bundle for one port of onchip_ram_dualport_arb.
// The master drives the request side; the RAM answers with waitrequest and read data.
interface onchip_ram_dualport_arb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_ram_dualport_arb.sv
// Single-port on-chip RAM shared by two Avalon-MM slaves: round-robin arbitration,
// pipelined reads (latency 1 or 2), out-of-range guard, write freeze and global stall.
module onchip_ram_dualport_arb #(
   parameter int    DATA_W       = 32,
   parameter int    DEPTH        = 10000,
   parameter int    ADDR_W       = 14,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "UNUSED"
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   input  logic reset_req,
   input  logic freeze,
   onchip_ram_dualport_arb_if.slave s1,
   onchip_ram_dualport_arb_if.slave s2
);

   localparam int              BE_W    = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic              stall;
   logic              req1, req2;
   logic              grant1, grant2;
   logic              rr_q, rr_d;
   logic              acc, acc_rd;
   logic              sel_port;
   logic              sel_wr;
   logic              in_range;
   logic              wr_en, rd_en;
   logic [ADDR_W-1:0] addr;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] ram_rd;

   logic              vld_p1_q, port_p1_q, inr_p1_q;
   logic [DATA_W-1:0] dat_p1;

   logic              out_vld, out_port;
   logic [DATA_W-1:0] out_dat;
   logic              pulse1, pulse2;
   logic [DATA_W-1:0] rdh1_q, rdh1_d, rdh2_q, rdh2_d;

   assign stall = ~clken | reset_req;
   assign req1  = s1.chipselect & (s1.read | s1.write);
   assign req2  = s2.chipselect & (s2.read | s2.write);

   // rr_q = 0 favours s1 on the next contended cycle, 1 favours s2.
   always_comb begin
      grant1 = req1 & (~req2 | ~rr_q);
      grant2 = req2 & (~req1 | rr_q);
      rr_d   = (req1 & req2 & ~stall) ? ~rr_q : rr_q;
   end

   assign s1.waitrequest = req1 & (stall | ~grant1);
   assign s2.waitrequest = req2 & (stall | ~grant2);

   always_comb begin
      sel_port = grant2;
      if (grant2) begin
         addr   = s2.address;
         sel_wr = s2.write;
         be     = s2.byteenable;
         wdata  = s2.writedata;
      end else begin
         addr   = s1.address;
         sel_wr = s1.write;
         be     = s1.byteenable;
         wdata  = s1.writedata;
      end
   end

   assign acc      = (grant1 | grant2) & ~stall;
   assign acc_rd   = acc & ~sel_wr;
   assign in_range = {1'b0, addr} < DEPTH_L;
   assign wr_en    = acc & sel_wr & in_range & ~freeze;
   assign rd_en    = acc_rd & in_range;

   // Array access: one write or one registered read per accepted cycle.
   generate
      if (INIT_FILE != "UNUSED") begin : g_mem_init
         (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
         always_ff @(posedge clk) begin
            if (wr_en)
               for (int b = 0; b < BE_W; b++)
                  if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            if (rd_en) ram_rd <= mem[addr];
         end
      end else begin : g_mem_plain
         logic [DATA_W-1:0] mem [DEPTH];
         always_ff @(posedge clk) begin
            if (wr_en)
               for (int b = 0; b < BE_W; b++)
                  if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            if (rd_en) ram_rd <= mem[addr];
         end
      end
   endgenerate

   // Stage p1: read tag {port, in_range} alongside the RAM output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q      <= 1'b0;
         vld_p1_q  <= 1'b0;
         port_p1_q <= 1'b0;
         inr_p1_q  <= 1'b0;
      end else if (!stall) begin
         rr_q      <= rr_d;
         vld_p1_q  <= acc_rd;
         port_p1_q <= sel_port;
         inr_p1_q  <= in_range;
      end
   end

   assign dat_p1 = inr_p1_q ? ram_rd : '0;

   // Stage p2 (latency 2 only): RAM output registered once more.
   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              vld_p2_q, port_p2_q;
         logic [DATA_W-1:0] dat_p2_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_p2_q  <= 1'b0;
               port_p2_q <= 1'b0;
            end else if (!stall) begin
               vld_p2_q  <= vld_p1_q;
               port_p2_q <= port_p1_q;
            end
         end

         always_ff @(posedge clk) begin
            if (!stall && vld_p1_q) dat_p2_q <= dat_p1;
         end

         assign out_vld  = vld_p2_q;
         assign out_port = port_p2_q;
         assign out_dat  = dat_p2_q;
      end else begin : g_lat1
         assign out_vld  = vld_p1_q;
         assign out_port = port_p1_q;
         assign out_dat  = dat_p1;
      end
   endgenerate

   // A held result is presented only in an unstalled cycle, so it pulses exactly once.
   assign pulse1 = out_vld & ~stall & ~out_port;
   assign pulse2 = out_vld & ~stall &  out_port;
   assign rdh1_d = pulse1 ? out_dat : rdh1_q;
   assign rdh2_d = pulse2 ? out_dat : rdh2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdh1_q <= '0;
         rdh2_q <= '0;
      end else begin
         rdh1_q <= rdh1_d;
         rdh2_q <= rdh2_d;
      end
   end

   assign s1.readdatavalid = pulse1;
   assign s2.readdatavalid = pulse2;
   assign s1.readdata      = rdh1_d;
   assign s2.readdata      = rdh2_d;

endmodule

// File: tb/tb_onchip_ram_dualport_arb.sv
// Bench for onchip_ram_dualport_arb: latency-1 and latency-2 instances share one stimulus
// stream and are scored every cycle against a transaction-level model of the memory.
module tb_onchip_ram_dualport_arb;

   localparam int DEPTH = 10000;
   localparam int AW    = 14;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          rem;
   } rd_t;

   logic clk;
   logic reset_n;
   logic clken;
   logic reset_req;
   logic freeze;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [int];
   int          rr;
   rd_t         pend_l1[$];
   rd_t         pend_l2[$];
   logic [31:0] hold [2][2];
   int          nvld [2][2];

   onchip_ram_dualport_arb_if #(.DATA_W(32), .ADDR_W(AW)) p1_s1 ();
   onchip_ram_dualport_arb_if #(.DATA_W(32), .ADDR_W(AW)) p1_s2 ();
   onchip_ram_dualport_arb_if #(.DATA_W(32), .ADDR_W(AW)) p2_s1 ();
   onchip_ram_dualport_arb_if #(.DATA_W(32), .ADDR_W(AW)) p2_s2 ();

   assign p2_s1.address    = p1_s1.address;
   assign p2_s1.chipselect = p1_s1.chipselect;
   assign p2_s1.read       = p1_s1.read;
   assign p2_s1.write      = p1_s1.write;
   assign p2_s1.byteenable = p1_s1.byteenable;
   assign p2_s1.writedata  = p1_s1.writedata;
   assign p2_s2.address    = p1_s2.address;
   assign p2_s2.chipselect = p1_s2.chipselect;
   assign p2_s2.read       = p1_s2.read;
   assign p2_s2.write      = p1_s2.write;
   assign p2_s2.byteenable = p1_s2.byteenable;
   assign p2_s2.writedata  = p1_s2.writedata;

   onchip_ram_dualport_arb #(
      .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1), .INIT_FILE("UNUSED")
   ) u_l1 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .freeze(freeze), .s1(p1_s1), .s2(p1_s2)
   );

   onchip_ram_dualport_arb #(
      .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2), .INIT_FILE("UNUSED")
   ) u_l2 (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .freeze(freeze), .s1(p2_s1), .s2(p2_s2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                         input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic drive(input int port, input bit cs, input bit rd, input bit wr,
                        input int addr, input logic [3:0] be, input logic [31:0] wd);
      if (port == 1) begin
         p1_s1.chipselect = cs;  p1_s1.read = rd;  p1_s1.write = wr;
         p1_s1.address = AW'(addr);  p1_s1.byteenable = be;  p1_s1.writedata = wd;
      end else begin
         p1_s2.chipselect = cs;  p1_s2.read = rd;  p1_s2.write = wr;
         p1_s2.address = AW'(addr);  p1_s2.byteenable = be;  p1_s2.writedata = wd;
      end
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 4'h0, 32'h0);
      drive(2, 0, 0, 0, 0, 4'h0, 32'h0);
   endtask

   task automatic model_reset();
      pend_l1.delete();
      pend_l2.delete();
      rr = 0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) hold[d][p] = '0;
   endtask

   // One clock of scoring: arbitration and returns predicted from the bus rules,
   // compared at the falling edge, then the accepted transfer is applied to the model.
   task automatic step();
      bit          stall, r1, r2, g1, g2;
      bit          ew [2];
      bit          ev [2][2];
      logic        wo [2][2];
      logic        vo [2][2];
      logic [31:0] dout [2][2];
      rd_t         q[$];
      rd_t         e;
      int          a;
      bit          is_wr;
      logic [3:0]  be;
      logic [31:0] wd;
      @(negedge clk);
      stall = !clken || reset_req;
      r1 = p1_s1.chipselect && (p1_s1.read || p1_s1.write);
      r2 = p1_s2.chipselect && (p1_s2.read || p1_s2.write);
      g1 = 0;
      g2 = 0;
      if (!stall) begin
         if (r1 && r2) begin
            g1 = (rr == 0);
            g2 = !g1;
            rr = 1 - rr;
         end else begin
            g1 = r1;
            g2 = r2;
         end
      end
      ew[0] = r1 && !g1;
      ew[1] = r2 && !g2;
      wo[0][0] = p1_s1.waitrequest;   wo[0][1] = p1_s2.waitrequest;
      wo[1][0] = p2_s1.waitrequest;   wo[1][1] = p2_s2.waitrequest;
      vo[0][0] = p1_s1.readdatavalid; vo[0][1] = p1_s2.readdatavalid;
      vo[1][0] = p2_s1.readdatavalid; vo[1][1] = p2_s2.readdatavalid;
      dout[0][0] = p1_s1.readdata;    dout[0][1] = p1_s2.readdata;
      dout[1][0] = p2_s1.readdata;    dout[1][1] = p2_s2.readdata;

      for (int d = 0; d < 2; d++) begin
         if (d == 0) q = pend_l1; else q = pend_l2;
         ev[d][0] = 0;
         ev[d][1] = 0;
         if (!stall) begin
            foreach (q[i]) q[i].rem = q[i].rem - 1;
            if (q.size() > 0 && q[0].rem == 0) begin
               e = q.pop_front();
               ev[d][e.port] = 1;
               hold[d][e.port] = e.data;
            end
         end
         if (d == 0) pend_l1 = q; else pend_l2 = q;
         for (int p = 0; p < 2; p++) begin
            checks++;
            if (wo[d][p] !== ew[p]) begin
               errors++;
               $display("FAIL lat%0d.s%0d waitrequest: got %b expected %b", d + 1, p + 1, wo[d][p], ew[p]);
            end
            checks++;
            if (vo[d][p] !== ev[d][p]) begin
               errors++;
               $display("FAIL lat%0d.s%0d readdatavalid: got %b expected %b", d + 1, p + 1, vo[d][p], ev[d][p]);
            end
            checks++;
            if (dout[d][p] !== hold[d][p]) begin
               errors++;
               $display("FAIL lat%0d.s%0d readdata: got %h expected %h", d + 1, p + 1, dout[d][p], hold[d][p]);
            end
            if (vo[d][p] === 1'b1) nvld[d][p]++;
         end
      end

      if (g1 || g2) begin
         if (g1) begin
            a = int'(p1_s1.address); is_wr = p1_s1.write; be = p1_s1.byteenable; wd = p1_s1.writedata;
         end else begin
            a = int'(p1_s2.address); is_wr = p1_s2.write; be = p1_s2.byteenable; wd = p1_s2.writedata;
         end
         if (is_wr) begin
            if (!freeze && a < DEPTH) mem[a] = merge(mem[a], be, wd);
         end else begin
            e.port = g1 ? 0 : 1;
            e.data = (a < DEPTH) ? mem[a] : 32'h0;
            e.rem  = 1;
            pend_l1.push_back(e);
            e.rem  = 2;
            pend_l2.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) nvld[d][p] = 0;
   endtask

   task automatic test_reset_state();
      reset_n = 1'b0;
      clken = 1'b1;
      reset_req = 1'b0;
      freeze = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({p1_s1.readdatavalid, p1_s2.readdatavalid, p2_s1.readdatavalid, p2_s2.readdatavalid} !== 4'b0) begin
         errors++;
         $display("FAIL reset readdatavalid: got %b%b%b%b expected 0000", p1_s1.readdatavalid,
                  p1_s2.readdatavalid, p2_s1.readdatavalid, p2_s2.readdatavalid);
      end
      checks++;
      if ((p1_s1.readdata | p1_s2.readdata | p2_s1.readdata | p2_s2.readdata) !== 32'h0) begin
         errors++;
         $display("FAIL reset readdata: got %h %h %h %h expected all 0", p1_s1.readdata,
                  p1_s2.readdata, p2_s1.readdata, p2_s2.readdata);
      end
      checks++;
      if ({p1_s1.waitrequest, p1_s2.waitrequest} !== 2'b00) begin
         errors++;
         $display("FAIL reset idle waitrequest: got %b%b expected 00", p1_s1.waitrequest, p1_s2.waitrequest);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int a = 0; a < 17; a++) begin
         drive(1, 1, 0, 1, (a == 16) ? DEPTH - 1 : a, 4'hF, $urandom | 32'h1);
         step();
      end
      idle();
      step();
   endtask

   task automatic test_reset_midread();
      drive(1, 1, 1, 0, 4, 4'h0, 32'h0);
      drive(2, 1, 1, 0, 3, 4'h0, 32'h0);
      step();
      step();
      idle();
      repeat (3) step();
      drive(1, 1, 1, 0, 3, 4'h0, 32'h0);
      step();
      idle();
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({p1_s1.readdatavalid, p1_s2.readdatavalid, p2_s1.readdatavalid, p2_s2.readdatavalid} !== 4'b0) begin
         errors++;
         $display("FAIL midread reset readdatavalid: got %b%b%b%b expected 0000", p1_s1.readdatavalid,
                  p1_s2.readdatavalid, p2_s1.readdatavalid, p2_s2.readdatavalid);
      end
      checks++;
      if ((p1_s1.readdata | p1_s2.readdata | p2_s1.readdata | p2_s2.readdata) !== 32'h0) begin
         errors++;
         $display("FAIL midread reset readdata: got %h %h %h %h expected all 0", p1_s1.readdata,
                  p1_s2.readdata, p2_s1.readdata, p2_s2.readdata);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      clear_counts();
      repeat (4) step();
      checks++;
      if (nvld[0][0] + nvld[1][0] + nvld[0][1] + nvld[1][1] != 0) begin
         errors++;
         $display("FAIL dropped read returned: got %0d pulses expected 0",
                  nvld[0][0] + nvld[1][0] + nvld[0][1] + nvld[1][1]);
      end
   endtask

   task automatic test_contention();
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 1, 0, i, 4'h0, 32'h0);
         drive(2, 1, 1, 0, 8 + i, 4'h0, 32'h0);
         #1;
         checks++;
         if ({p1_s1.waitrequest, p1_s2.waitrequest} !== {(i % 2 == 1), (i % 2 == 0)}) begin
            errors++;
            $display("FAIL contention cycle %0d waitrequest s1,s2: got %b%b expected %b%b", i,
                     p1_s1.waitrequest, p1_s2.waitrequest, (i % 2 == 1), (i % 2 == 0));
         end
         step();
      end
      idle();
      repeat (3) step();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            checks++;
            if (nvld[d][p] != 4) begin
               errors++;
               $display("FAIL contention pulses lat%0d.s%0d: got %0d expected 4", d + 1, p + 1, nvld[d][p]);
            end
         end
   endtask

   task automatic test_byte_write();
      drive(1, 1, 0, 1, 5, 4'hF, 32'h0);
      step();
      drive(1, 1, 0, 1, 5, 4'b0101, 32'hDEADBEEF);
      step();
      drive(1, 1, 1, 0, 5, 4'h0, 32'h0);
      step();
      idle();
      checks++;
      if (p1_s1.readdatavalid !== 1'b1 || p1_s1.readdata !== 32'h00AD00EF) begin
         errors++;
         $display("FAIL byte write lat1: got valid=%b data=%h expected valid=1 data=00ad00ef",
                  p1_s1.readdatavalid, p1_s1.readdata);
      end
      checks++;
      if (p2_s1.readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL byte write lat2 early: got valid=%b expected 0", p2_s1.readdatavalid);
      end
      step();
      checks++;
      if (p2_s1.readdatavalid !== 1'b1 || p2_s1.readdata !== 32'h00AD00EF) begin
         errors++;
         $display("FAIL byte write lat2: got valid=%b data=%h expected valid=1 data=00ad00ef",
                  p2_s1.readdatavalid, p2_s1.readdata);
      end
      step();
   endtask

   task automatic test_freeze();
      drive(1, 1, 0, 1, 7, 4'hF, 32'h11112222);
      step();
      idle();
      freeze = 1'b1;
      drive(2, 1, 0, 1, 7, 4'hF, 32'h12345678);
      #1;
      checks++;
      if (p1_s2.waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL freeze write waitrequest: got %b expected 0", p1_s2.waitrequest);
      end
      step();
      freeze = 1'b0;
      drive(2, 0, 0, 0, 0, 4'h0, 32'h0);
      drive(1, 1, 1, 0, 7, 4'h0, 32'h0);
      step();
      idle();
      step();
      checks++;
      if (p2_s1.readdatavalid !== 1'b1 || p2_s1.readdata !== 32'h11112222) begin
         errors++;
         $display("FAIL freeze readback lat2: got valid=%b data=%h expected valid=1 data=11112222",
                  p2_s1.readdatavalid, p2_s1.readdata);
      end
      step();
   endtask

   task automatic test_out_of_range();
      drive(1, 1, 1, 0, 4, 4'h0, 32'h0);
      step();
      idle();
      repeat (2) step();
      drive(2, 1, 0, 1, DEPTH, 4'hF, 32'hFFFFFFFF);
      step();
      idle();
      drive(1, 1, 1, 0, DEPTH, 4'h0, 32'h0);
      step();
      idle();
      checks++;
      if (p1_s1.readdatavalid !== 1'b1 || p1_s1.readdata !== 32'h0) begin
         errors++;
         $display("FAIL out of range lat1: got valid=%b data=%h expected valid=1 data=0",
                  p1_s1.readdatavalid, p1_s1.readdata);
      end
      step();
      checks++;
      if (p2_s1.readdatavalid !== 1'b1 || p2_s1.readdata !== 32'h0) begin
         errors++;
         $display("FAIL out of range lat2: got valid=%b data=%h expected valid=1 data=0",
                  p2_s1.readdatavalid, p2_s1.readdata);
      end
      step();
   endtask

   task automatic test_stall();
      logic [31:0] x1, x2;
      x1 = mem[1];
      x2 = mem[2];
      drive(1, 1, 1, 0, 1, 4'h0, 32'h0);
      step();
      idle();
      drive(2, 1, 1, 0, 2, 4'h0, 32'h0);
      step();
      idle();
      clken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({p2_s1.readdatavalid, p2_s2.readdatavalid} !== 2'b00) begin
            errors++;
            $display("FAIL stall cycle %0d lat2 valids: got %b%b expected 00", i,
                     p2_s1.readdatavalid, p2_s2.readdatavalid);
         end
         step();
      end
      clken = 1'b1;
      #1;
      checks++;
      if (p2_s1.readdatavalid !== 1'b1 || p2_s1.readdata !== x1) begin
         errors++;
         $display("FAIL stall resume s1 lat2: got valid=%b data=%h expected valid=1 data=%h",
                  p2_s1.readdatavalid, p2_s1.readdata, x1);
      end
      step();
      checks++;
      if (p2_s2.readdatavalid !== 1'b1 || p2_s2.readdata !== x2) begin
         errors++;
         $display("FAIL stall resume s2 lat2: got valid=%b data=%h expected valid=1 data=%h",
                  p2_s2.readdatavalid, p2_s2.readdata, x2);
      end
      step();
   endtask

   function automatic int pick_addr();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 16) return r;
      if (r == 16) return DEPTH - 1;
      if (r == 17) return DEPTH;
      if (r == 18) return 16383;
      return 5;
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int p = 1; p <= 2; p++)
            drive(p, ($urandom % 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  pick_addr(), 4'($urandom), $urandom);
         freeze    = ($urandom % 10) == 0;
         clken     = ($urandom % 8) != 0;
         reset_req = ($urandom % 16) == 0;
         step();
      end
      idle();
      freeze = 1'b0;
      clken = 1'b1;
      reset_req = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      test_reset_state();
      preload();
      test_reset_midread();
      test_contention();
      test_byte_write();
      test_freeze();
      test_out_of_range();
      test_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
